arith_enc_scheduler: RTL and testbench
======================================

// Module: arith_enc_scheduler
// PURPOSE
//  Frame-level controller in front of the 3-deep arithmetic encoder pipeline (stage_1 -> stage_2 -> stage_3_4_5).
//  Accepts (fl, fh, symbol, nsyms) over valid/ready and issues them to the encoder.
//  Spaces issues so that each stage_2 read of range/low sees the previous symbol's committed result.
//  Generates per-stage register enables, holds the encoder in reset between frames, drains the pipe and flags frame completion.
// PARAMETERS
//  DATA_16       16  width of fl/fh
//  SYMBOL_WIDTH   4  symbol width; nsyms is SYMBOL_WIDTH+1 bits
//  ISSUE_GAP      2  cycles between issues; values below 2 are clamped to 2 (range/low feedback hazard)
//  INIT_CYCLES    2  cycles enc_reset is held at frame start, min 1
//  CNT_WIDTH     32  width of sym_count
// PORTS
//  general_clk  in   1              clock, all logic on rising edge
//  reset        in   1              synchronous, active-high
//  frame_start  in   1              request new frame; honoured only in IDLE
//  in_valid     in   1              input operands valid
//  in_ready     out  1              scheduler can accept this cycle
//  in_last      in   1              qualifies the final symbol of the frame
//  in_fl,in_fh  in   DATA_16        CDF bounds
//  in_symbol    in   SYMBOL_WIDTH   symbol
//  in_nsyms     in   SYMBOL_WIDTH+1 alphabet size
//  enc_reset    out  1              drives the encoder reset
//  enc_fl,enc_fh,enc_symbol,enc_nsyms  out  as inputs   registered operands to stage_1
//  en_s1,en_s2,en_s3  out  1        load enables for the stage-1, stage-2 and stage-3 registers
//  res_valid    out  1              encoder RANGE/LOW/CNT outputs hold a new committed result
//  busy         out  1              state != IDLE
//  frame_done   out  1              1-cycle pulse when the last result is committed
//  sym_count    out  CNT_WIDTH      symbols issued in the current frame, saturating
// BEHAVIOUR
//  Reset values
//  - state=IDLE; enc_reset=1; in_ready, en_s*, res_valid, busy, frame_done = 0; enc_* = 0; sym_count = 0.
//  - reset mid-frame aborts immediately; any in-flight symbols are discarded (enables cleared).
//  FSM states: IDLE, INIT, RUN, GAP, DRAIN
//  - IDLE: enc_reset=1.
//    - frame_start -> INIT; sym_count cleared.
//  - INIT: enc_reset=1 for INIT_CYCLES cycles (down-counter), then -> RUN with enc_reset=0.
//  - RUN: in_ready=1.
//    - On accept (in_valid & in_ready): register operands to enc_*; en_s1 pulses in the next cycle; sym_count += 1.
//    - Next state on accept: DRAIN if in_last, else GAP. With no accept, stay in RUN and keep en_s1=0.
//  - GAP: in_ready=0 for ISSUE_GAP-1 cycles, then -> RUN.
//    - Throughput: 1 symbol per ISSUE_GAP cycles. Symbol accepted at cycle t is issued (en_s1) at t+1.
//  - DRAIN: in_ready=0; wait until the valid pipe is empty and en_s3 of the last symbol has fired.
//    - Then frame_done=1 for 1 cycle and -> IDLE.
//  Valid pipe
//  - en_s2(t) = en_s1(t-1); en_s3(t) = en_s2(t-1); res_valid(t) = en_s3(t-1).
//  - Issue-to-res_valid latency: 3 cycles.
//  Boundaries
//  - frame_start in non-IDLE: ignored.
//  - frame_start in the same cycle frame_done is pulsed: honoured (state is already IDLE that cycle).
//  - in_last without in_valid: ignored.
//  - in_valid is never accepted outside RUN. enc_* hold their value between issues.
//  - sym_count saturates at all-ones and does not wrap.
//  - An empty frame cannot be expressed: a frame ends only on an accepted in_last.
// STRUCTURE
//  - arith_enc_pkg: state enum (IDLE/INIT/RUN/GAP/DRAIN), PIPE_DEPTH=3, MIN_ISSUE_GAP=2, the gap clamp function.
//  - Sub-module arith_enc_valid_pipe: PIPE_DEPTH-bit valid shift register producing en_s2, en_s3, res_valid, plus an empty flag.
//  - Top level: FSM, gap/init counter, operand registers, sym_count.
// TESTING
//  1 reset=1 3 cycles -> enc_reset=1, in_ready=0, busy=0, sym_count=0, all enables 0.
//  2 frame_start, INIT_CYCLES=2 -> enc_reset high 2 cycles after IDLE exit, in_ready=1 on cycle 3.
//  3 back-to-back in_valid with fl=0x4000 fh=0x2000 nsyms=5 -> accepts every 2nd cycle; en_s1 at t+1, res_valid at t+4.
//  4 frame of 4 symbols, last with in_last -> sym_count=4; frame_done 1 cycle after the final res_valid; then IDLE.
//  5 reset asserted 1 cycle after an accept -> next cycle all enables 0, IDLE, enc_reset=1, no res_valid.
//  6 frame_start during RUN and on the frame_done cycle -> first ignored, second starts INIT; sym_count reload to 0.

Source files
------------

// File: rtl/arith_enc_pkg.sv
// arith_enc_pkg: shared state encoding, pipeline constants and issue-gap clamp
package arith_enc_pkg;
   typedef enum logic [2:0] {IDLE, INIT, RUN, GAP, DRAIN} state_t;
   localparam int PIPE_DEPTH    = 3;
   localparam int MIN_ISSUE_GAP = 2;
   localparam int TMR_W         = 16;
   // a gap below two would let stage_2 read range/low before the previous symbol commits
   function automatic int clamp_gap(input int gap);
      return (gap < MIN_ISSUE_GAP) ? MIN_ISSUE_GAP : gap;
   endfunction
endpackage

// File: rtl/arith_enc_scheduler_if.sv
// arith_enc_scheduler_if: operand handshake, encoder drive and status bundle
interface arith_enc_scheduler_if #(
   parameter int DATA_16      = 16,
   parameter int SYMBOL_WIDTH = 4,
   parameter int CNT_WIDTH    = 32
) ();
   logic                    frame_start, in_valid, in_ready, in_last;
   logic [DATA_16-1:0]      in_fl, in_fh, enc_fl, enc_fh;
   logic [SYMBOL_WIDTH-1:0] in_symbol, enc_symbol;
   logic [SYMBOL_WIDTH:0]   in_nsyms, enc_nsyms;
   logic                    enc_reset, en_s1, en_s2, en_s3, res_valid, busy, frame_done;
   logic [CNT_WIDTH-1:0]    sym_count;
   modport master (
      output frame_start, in_valid, in_last, in_fl, in_fh, in_symbol, in_nsyms,
      input  in_ready, enc_reset, enc_fl, enc_fh, enc_symbol, enc_nsyms,
      input  en_s1, en_s2, en_s3, res_valid, busy, frame_done, sym_count
   );
   modport slave (
      input  frame_start, in_valid, in_last, in_fl, in_fh, in_symbol, in_nsyms,
      output in_ready, enc_reset, enc_fl, enc_fh, enc_symbol, enc_nsyms,
      output en_s1, en_s2, en_s3, res_valid, busy, frame_done, sym_count
   );
endinterface

// File: rtl/arith_enc_valid_pipe.sv
// arith_enc_valid_pipe: shifts the stage-1 issue strobe into later-stage enables
module arith_enc_valid_pipe
   import arith_enc_pkg::*;
(
   input  logic general_clk,
   input  logic reset,
   input  logic i_en_s1,
   output logic o_en_s2,
   output logic o_en_s3,
   output logic o_res_valid,
   output logic o_empty
);
   logic [PIPE_DEPTH-1:0] r_v;
   always_ff @(posedge general_clk) begin
      if (reset) r_v <= '0;
      else       r_v <= {r_v[PIPE_DEPTH-2:0], i_en_s1};
   end
   assign o_en_s2     = r_v[0];
   assign o_en_s3     = r_v[1];
   assign o_res_valid = r_v[PIPE_DEPTH-1];
   // empty once no stage enable is still to fire; res_valid may be showing the last result
   assign o_empty     = ~|{i_en_s1, r_v[PIPE_DEPTH-2:0]};
endmodule

// File: rtl/arith_enc_scheduler.sv
// arith_enc_scheduler: paces operand issue into the 3-stage arithmetic encoder per frame
module arith_enc_scheduler
   import arith_enc_pkg::*;
#(
   parameter int DATA_16      = 16,
   parameter int SYMBOL_WIDTH = 4,
   parameter int ISSUE_GAP    = 2,
   parameter int INIT_CYCLES  = 2,
   parameter int CNT_WIDTH    = 32
) (
   input logic general_clk,
   input logic reset,
   arith_enc_scheduler_if.slave bus
);
   localparam int GAP_CYC  = clamp_gap(ISSUE_GAP);
   localparam int INIT_CYC = (INIT_CYCLES < 1) ? 1 : INIT_CYCLES;

   state_t                  r_state, w_next;
   logic [TMR_W-1:0]        r_tmr, w_tmr;
   logic                    r_en_s1, r_done, w_accept, w_done, w_empty;
   logic [CNT_WIDTH-1:0]    r_cnt;
   logic [DATA_16-1:0]      r_fl, r_fh;
   logic [SYMBOL_WIDTH-1:0] r_symbol;
   logic [SYMBOL_WIDTH:0]   r_nsyms;

   always_comb begin
      w_next   = r_state;
      w_tmr    = r_tmr;
      w_done   = 1'b0;
      w_accept = (r_state == RUN) && bus.in_valid;
      case (r_state)
         IDLE: if (bus.frame_start) begin
            w_next = INIT;
            w_tmr  = TMR_W'(INIT_CYC - 1);
         end
         INIT: if (r_tmr == '0) w_next = RUN;
               else             w_tmr  = r_tmr - TMR_W'(1);
         RUN: if (w_accept) begin
            w_next = bus.in_last ? DRAIN : GAP;
            w_tmr  = TMR_W'(GAP_CYC - 2);
         end
         GAP: if (r_tmr == '0) w_next = RUN;
              else             w_tmr  = r_tmr - TMR_W'(1);
         DRAIN: if (w_empty) begin
            w_next = IDLE;
            w_done = 1'b1;
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge general_clk) begin
      if (reset) begin
         r_state  <= IDLE;
         r_tmr    <= '0;
         r_en_s1  <= 1'b0;
         r_done   <= 1'b0;
         r_cnt    <= '0;
         r_fl     <= '0;
         r_fh     <= '0;
         r_symbol <= '0;
         r_nsyms  <= '0;
      end else begin
         r_state <= w_next;
         r_tmr   <= w_tmr;
         r_en_s1 <= w_accept;
         r_done  <= w_done;
         if (w_accept) begin
            r_fl     <= bus.in_fl;
            r_fh     <= bus.in_fh;
            r_symbol <= bus.in_symbol;
            r_nsyms  <= bus.in_nsyms;
         end
         if (r_state == IDLE && bus.frame_start) r_cnt <= '0;
         else if (w_accept && !(&r_cnt))         r_cnt <= r_cnt + CNT_WIDTH'(1);
      end
   end

   arith_enc_valid_pipe u_pipe (
      .general_clk (general_clk),
      .reset       (reset),
      .i_en_s1     (r_en_s1),
      .o_en_s2     (bus.en_s2),
      .o_en_s3     (bus.en_s3),
      .o_res_valid (bus.res_valid),
      .o_empty     (w_empty)
   );

   assign bus.in_ready   = (r_state == RUN);
   assign bus.busy       = (r_state != IDLE);
   assign bus.enc_reset  = (r_state == IDLE) || (r_state == INIT);
   assign bus.en_s1      = r_en_s1;
   assign bus.frame_done = r_done;
   assign bus.sym_count  = r_cnt;
   assign bus.enc_fl     = r_fl;
   assign bus.enc_fh     = r_fh;
   assign bus.enc_symbol = r_symbol;
   assign bus.enc_nsyms  = r_nsyms;
endmodule

// File: tb/tb_arith_enc_scheduler.sv
// tb_arith_enc_scheduler: scoreboard bench for issue pacing, pipe latency and frame control
module tb_arith_enc_scheduler;
   typedef struct {
      logic [15:0] fl;
      logic [15:0] fh;
      logic [3:0]  s;
      logic [4:0]  n;
      int          cyc;
   } iss_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rst_q = 1'b1;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_err = 0;
   int   exp_cnt = 0;
   int   last_acc = -1;
   int   last_res = -100;
   logic p1 = 1'b0, p2 = 1'b0, p3 = 1'b0;
   iss_t issue_q[$];
   int   res_q[$];

   arith_enc_scheduler_if #(.DATA_16(16), .SYMBOL_WIDTH(4), .CNT_WIDTH(32)) bus ();

   arith_enc_scheduler #(
      .DATA_16(16), .SYMBOL_WIDTH(4), .ISSUE_GAP(2), .INIT_CYCLES(2), .CNT_WIDTH(32)
   ) dut (
      .general_clk (clk),
      .reset       (rst),
      .bus         (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc   <= cyc + 1;
      rst_q <= rst;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // scoreboard side: issue operands and per-stage timing
   always @(negedge clk) begin
      iss_t e;
      if (rst_q) begin
         p1 = 1'b0; p2 = 1'b0; p3 = 1'b0;
         issue_q.delete();
         res_q.delete();
      end else begin
         chk("en_s2_follow", bus.en_s2, p1);
         chk("en_s3_follow", bus.en_s3, p2);
         chk("res_follow", bus.res_valid, p3);
         if (bus.en_s1) begin
            chk("issue_pending", issue_q.size() > 0, 1);
            if (issue_q.size() > 0) begin
               e = issue_q.pop_front();
               chk("enc_fl", bus.enc_fl, e.fl);
               chk("enc_fh", bus.enc_fh, e.fh);
               chk("enc_symbol", bus.enc_symbol, e.s);
               chk("enc_nsyms", bus.enc_nsyms, e.n);
               chk("issue_lat", cyc - e.cyc, 1);
               res_q.push_back(cyc);
            end
         end
         if (bus.res_valid) begin
            chk("res_pending", res_q.size() > 0, 1);
            if (res_q.size() > 0) begin
               chk("res_lat", cyc - res_q.pop_front(), 3);
               last_res = cyc;
            end
         end
         p1 = bus.en_s1; p2 = bus.en_s2; p3 = bus.en_s3;
      end
   end

   task automatic init_checks();
      @(negedge clk);
      bus.frame_start = 1'b0;
      chk("init1_enc_reset", bus.enc_reset, 1);
      chk("init1_ready", bus.in_ready, 0);
      chk("init1_busy", bus.busy, 1);
      chk("init1_cnt", bus.sym_count, 0);
      @(negedge clk);
      chk("init2_enc_reset", bus.enc_reset, 1);
      chk("init2_ready", bus.in_ready, 0);
      @(negedge clk);
      chk("run_ready", bus.in_ready, 1);
      chk("run_enc_reset", bus.enc_reset, 0);
      exp_cnt  = 0;
      last_acc = -1;
   endtask

   task automatic send(input logic [15:0] fl, input logic [15:0] fh, input logic [3:0] s,
                       input logic [4:0] n, input bit last, input bit b2b);
      int w = 0;
      bus.in_valid = 1'b1; bus.in_last = last;
      bus.in_fl = fl; bus.in_fh = fh; bus.in_symbol = s; bus.in_nsyms = n;
      while (!bus.in_ready && w < 20) begin
         @(negedge clk);
         w++;
      end
      chk("accept_wait", w < 20, 1);
      if (b2b) chk("issue_gap", cyc - last_acc, 2);
      last_acc = cyc;
      issue_q.push_back('{fl, fh, s, n, cyc});
      exp_cnt++;
      @(negedge clk);
      bus.in_valid = 1'b0; bus.in_last = 1'b0;
      chk("sym_count", bus.sym_count, exp_cnt);
   endtask

   task automatic wait_done(input bit restart);
      int w = 0;
      while (!bus.frame_done && w < 30) begin
         @(negedge clk);
         w++;
      end
      chk("done_seen", bus.frame_done, 1);
      chk("done_after_res", cyc - last_res, 1);
      chk("done_idle", bus.busy, 0);
      chk("drain_empty", issue_q.size() + res_q.size(), 0);
      if (restart) bus.frame_start = 1'b1;
      else begin
         @(negedge clk);
         chk("done_pulse", bus.frame_done, 0);
         chk("idle_enc_reset", bus.enc_reset, 1);
      end
   endtask

   initial begin
      bus.frame_start = 1'b0; bus.in_valid = 1'b0; bus.in_last = 1'b0;
      bus.in_fl = '0; bus.in_fh = '0; bus.in_symbol = '0; bus.in_nsyms = '0;
      repeat (3) @(negedge clk);
      chk("rst_enc_reset", bus.enc_reset, 1);
      chk("rst_ready", bus.in_ready, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_cnt", bus.sym_count, 0);
      chk("rst_enables", {bus.en_s1, bus.en_s2, bus.en_s3, bus.res_valid, bus.frame_done}, 0);
      chk("rst_enc_fl", bus.enc_fl, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_busy", bus.busy, 0);

      // fixed-operand frame of four, issued back to back
      bus.frame_start = 1'b1;
      init_checks();
      for (int i = 0; i < 4; i++)
         send(16'h4000, 16'h2000, 4'(i), 5'd5, i == 3, i > 0);
      chk("frame_cnt", bus.sym_count, 4);
      wait_done(0);

      // random frame; a stray in_last without in_valid must not end it
      bus.frame_start = 1'b1;
      init_checks();
      send(16'($urandom), 16'($urandom), 4'($urandom), 5'($urandom), 1'b0, 1'b0);
      bus.in_last = 1'b1;
      @(negedge clk);
      @(negedge clk);
      bus.in_last = 1'b0;
      chk("stray_last_ready", bus.in_ready, 1);
      for (int i = 0; i < 3; i++)
         send(16'($urandom), 16'($urandom), 4'($urandom), 5'($urandom), i == 2, i > 0);
      wait_done(0);

      // reset one cycle after an accept throws away the in-flight symbol
      bus.frame_start = 1'b1;
      init_checks();
      send(16'h1234, 16'h0100, 4'd7, 5'd9, 1'b0, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_enables", {bus.en_s1, bus.en_s2, bus.en_s3, bus.res_valid}, 0);
      chk("abort_busy", bus.busy, 0);
      chk("abort_enc_reset", bus.enc_reset, 1);
      rst = 1'b0;
      repeat (6) @(negedge clk);
      chk("abort_quiet", bus.busy, 0);

      // frame_start ignored in RUN, honoured on the frame_done cycle
      bus.frame_start = 1'b1;
      init_checks();
      bus.frame_start = 1'b1;
      @(negedge clk);
      bus.frame_start = 1'b0;
      chk("fs_run_enc_reset", bus.enc_reset, 0);
      chk("fs_run_ready", bus.in_ready, 1);
      for (int i = 0; i < 3; i++)
         send(16'($urandom), 16'($urandom), 4'($urandom), 5'($urandom), i == 2, i > 0);
      wait_done(1);
      init_checks();
      for (int i = 0; i < 2; i++)
         send(16'($urandom), 16'($urandom), 4'($urandom), 5'($urandom), i == 1, i > 0);
      chk("restart_cnt", bus.sym_count, 2);
      wait_done(0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: run did not complete, checks %0d errors %0d", n_chk, n_err);
      $fatal(1);
   end
endmodule
